// File: rtl/dmem_axi_wr.sv
// dmem_axi_wr: AXI write-channel responder in front of a word-addressed data
// memory. One AW descriptor, then awlen+1 W beats with byte strobes, then one
// B response. A registered debug read port exposes the memory contents.
// Optional build macro: DMEM_OOR_CHECK_EN. When it is defined, beats whose
// full word address is past the end of the array are dropped and flagged as
// SLVERR. When it is undefined, the word index wraps modulo DEPTH_WORDS.
module dmem_axi_wr #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   output logic                  bvalid,
   input  logic                  bready,
   output logic [1:0]            bresp,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_rdata
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int WA_W  = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RESP
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [WA_W-1:0]       r_wordAddr;
   logic [8:0]            r_beatsLeft;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic                  w_awHs;
   logic                  w_wHs;
   logic                  w_finalBeat;
   logic                  w_inRange;
   logic                  w_beatErr;
   logic [IDX_W-1:0]      w_wrIdx;
   logic [IDX_W-1:0]      w_dbgIdx;
   logic                  w_unused;

   assign w_awHs      = awvalid && awready;
   assign w_wHs       = wvalid && wready;
   assign w_finalBeat = (r_beatsLeft == 9'd1);
   assign w_wrIdx     = r_wordAddr[IDX_W-1:0];
   assign w_dbgIdx    = dbg_addr[IDX_W+1:2];

`ifdef DMEM_OOR_CHECK_EN
   // The full word address is kept, so anything at or past the array end is refused.
   assign w_inRange = (r_wordAddr < WA_W'(DEPTH_WORDS));
`else
   // Upper address bits are ignored; the low index bits wrap naturally.
   assign w_inRange = 1'b1;
`endif

   // A beat is flagged when wlast disagrees with the beat count or the word is out of range.
   assign w_beatErr = (wlast != w_finalBeat) || !w_inRange;

   // Byte-offset bits and address bits above the index carry no information here.
   assign w_unused = &{1'b0, awaddr[1:0], dbg_addr, r_wordAddr};

   // State register; reset abandons any burst in flight without a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and handshake outputs; everything is held low while rst is high.
   always_comb begin
      w_nextState = r_state;
      awready     = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      bresp       = 2'b00;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               awready = 1'b1;
               if (awvalid) begin
                  w_nextState = DATA;
               end
            end
            DATA: begin
               wready = 1'b1;
               if (wvalid && w_finalBeat) begin
                  w_nextState = RESP;
               end
            end
            RESP: begin
               bvalid = 1'b1;
               bresp  = r_err ? 2'b10 : 2'b00;
               if (bready) begin
                  w_nextState = IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Burst bookkeeping: word address, remaining beat count and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wordAddr  <= '0;
         r_beatsLeft <= '0;
         r_err       <= 1'b0;
      end else if (w_awHs) begin
         r_wordAddr  <= awaddr[ADDR_WIDTH-1:2];
         r_beatsLeft <= {1'b0, awlen} + 9'd1;
         r_err       <= 1'b0;
      end else if (w_wHs) begin
         r_wordAddr  <= r_wordAddr + 1'b1;
         r_beatsLeft <= r_beatsLeft - 9'd1;
         if (w_beatErr) begin
            r_err <= 1'b1;
         end
      end
   end

   // Byte-masked memory write; the array itself is never cleared by reset.
   always_ff @(posedge clk) begin
      if (w_wHs && w_inRange) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               r_mem[w_wrIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered debug read; a same-cycle write to the same word shows the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_rdata <= '0;
      end else begin
         dbg_rdata <= r_mem[w_dbgIdx];
      end
   end

endmodule

// File: tb/tb_dmem_axi_wr.sv
// tb_dmem_axi_wr: directed bench for dmem_axi_wr. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, so nothing races the edge.
// Honours DMEM_OOR_CHECK_EN for the wrap / out-of-range scenario.
module tb_dmem_axi_wr;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_rdata;

   int testCount = 0;
   int failCount = 0;
   int wHsCount  = 0;
   int bHsCount  = 0;

   dmem_axi_wr #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_WORDS(1024)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .awvalid  (awvalid),
      .awready  (awready),
      .awaddr   (awaddr),
      .awlen    (awlen),
      .wvalid   (wvalid),
      .wready   (wready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wlast    (wlast),
      .bvalid   (bvalid),
      .bready   (bready),
      .bresp    (bresp),
      .dbg_addr (dbg_addr),
      .dbg_rdata(dbg_rdata)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Count W and B handshakes as seen on the rising edge.
   always @(posedge clk) begin
      if (wvalid && wready) wHsCount++;
      if (bvalid && bready) bHsCount++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendAw(input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      awaddr  = addr;
      awlen   = len;
      awvalid = 1'b1;
      while (awready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL aw_timeout: awready stayed %b, required 1", awready);
      end
      tick();
      awvalid = 1'b0;
   endtask

   task automatic sendBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      wdata  = data;
      wstrb  = strb;
      wlast  = last;
      wvalid = 1'b1;
      while (wready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL w_timeout: wready stayed %b, required 1", wready);
      end
      tick();
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic getResp(output logic [1:0] resp);
      int n = 0;
      bready = 1'b1;
      while (bvalid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL b_timeout: bvalid stayed %b, required 1", bvalid);
      end
      resp = bresp;
      tick();
      bready = 1'b0;
   endtask

   task automatic readWord(input logic [31:0] addr, output logic [31:0] data);
      dbg_addr = addr;
      tick();
      data = dbg_rdata;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      testCount++;
      if ({awready, wready, bvalid, bresp} !== 5'b0) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got aw/w/b/resp=%b, required 00000", {awready, wready, bvalid, bresp});
      end
      testCount++;
      if (dbg_rdata !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL reset_dbg: got %h, required 00000000", dbg_rdata);
      end
      rst = 1'b0;
      tick();
      testCount++;
      if (awready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_release_awready: got %b, required 1", awready);
      end
   endtask

   task automatic test_single_beat();
      logic [31:0] rd;
      awaddr  = 32'h0000_0010;
      awlen   = 8'd0;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      testCount++;
      if ({awready, wready, bvalid} !== 3'b010) begin
         failCount++;
         $display("[TB] FAIL single_t1: got aw/w/b=%b, required 010", {awready, wready, bvalid});
      end
      wdata  = 32'hDEAD_BEEF;
      wstrb  = 4'hF;
      wlast  = 1'b1;
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      wlast  = 1'b0;
      testCount++;
      if ({wready, bvalid, bresp} !== 4'b0100) begin
         failCount++;
         $display("[TB] FAIL single_t2: got w/b/resp=%b, required 0100", {wready, bvalid, bresp});
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      testCount++;
      if ({awready, bvalid} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL single_after_b: got aw/b=%b, required 10", {awready, bvalid});
      end
      readWord(32'h10, rd);
      testCount++;
      if (rd !== 32'hDEAD_BEEF) begin
         failCount++;
         $display("[TB] FAIL single_data: got %h, required deadbeef", rd);
      end
   endtask

   task automatic test_strobes();
      logic [1:0]  resp;
      logic [31:0] rd;
      sendAw(32'h20, 8'd0);
      sendBeat(32'h1122_3344, 4'hF, 1'b1);
      getResp(resp);
      sendAw(32'h20, 8'd0);
      sendBeat(32'hAABB_CCDD, 4'b0101, 1'b1);
      getResp(resp);
      testCount++;
      if (resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL strobe_resp: got %b, required 00", resp);
      end
      readWord(32'h20, rd);
      testCount++;
      if (rd !== 32'h11BB_33DD) begin
         failCount++;
         $display("[TB] FAIL strobe_data: got %h, required 11bb33dd", rd);
      end
   endtask

   task automatic test_burst_gaps();
      logic [1:0]  resp;
      logic [31:0] rd;
      wHsCount = 0;
      bHsCount = 0;
      sendAw(32'h40, 8'd3);
      sendBeat(32'd1, 4'hF, 1'b0);
      sendBeat(32'd2, 4'hF, 1'b0);
      tick();
      tick();
      testCount++;
      if ({wready, bvalid} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL burst_stall: got w/b=%b, required 10", {wready, bvalid});
      end
      sendBeat(32'd3, 4'hF, 1'b0);
      sendBeat(32'd4, 4'hF, 1'b1);
      getResp(resp);
      testCount++;
      if (resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL burst_resp: got %b, required 00", resp);
      end
      tick();
      tick();
      testCount++;
      if (wHsCount !== 4 || bHsCount !== 1 || bvalid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL burst_counts: got w=%0d b=%0d bvalid=%b, required w=4 b=1 bvalid=0", wHsCount, bHsCount, bvalid);
      end
      for (int i = 0; i < 4; i++) begin
         readWord(32'h40 + 32'(4 * i), rd);
         testCount++;
         if (rd !== 32'(i + 1)) begin
            failCount++;
            $display("[TB] FAIL burst_data%0d: got %h, required %h", i, rd, 32'(i + 1));
         end
      end
   endtask

   task automatic test_wlast_error();
      logic [31:0] rd;
      int n = 0;
      sendAw(32'h80, 8'd1);
      sendBeat(32'hCAFE_0000, 4'hF, 1'b1);
      sendBeat(32'hCAFE_0001, 4'hF, 1'b1);
      while (bvalid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         testCount++;
         if ({bvalid, bresp, awready} !== 4'b1100) begin
            failCount++;
            $display("[TB] FAIL wlast_hold%0d: got b/resp/aw=%b, required 1100", i, {bvalid, bresp, awready});
         end
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      testCount++;
      if ({bvalid, awready} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL wlast_release: got b/aw=%b, required 01", {bvalid, awready});
      end
      readWord(32'h80, rd);
      testCount++;
      if (rd !== 32'hCAFE_0000) begin
         failCount++;
         $display("[TB] FAIL wlast_data0: got %h, required cafe0000", rd);
      end
      readWord(32'h84, rd);
      testCount++;
      if (rd !== 32'hCAFE_0001) begin
         failCount++;
         $display("[TB] FAIL wlast_data1: got %h, required cafe0001", rd);
      end
   endtask

   task automatic test_wrap();
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [31:0] expWord0;
      logic [1:0]  expResp;
`ifdef DMEM_OOR_CHECK_EN
      expWord0 = 32'h5A5A_5A5A;
      expResp  = 2'b10;
`else
      expWord0 = 32'hBBBB_0002;
      expResp  = 2'b00;
`endif
      sendAw(32'h0, 8'd0);
      sendBeat(32'h5A5A_5A5A, 4'hF, 1'b1);
      getResp(resp);
      sendAw(32'h0FFC, 8'd1);
      sendBeat(32'hAAAA_0001, 4'hF, 1'b0);
      sendBeat(32'hBBBB_0002, 4'hF, 1'b1);
      getResp(resp);
      testCount++;
      if (resp !== expResp) begin
         failCount++;
         $display("[TB] FAIL wrap_resp: got %b, required %b", resp, expResp);
      end
      readWord(32'h0FFC, rd);
      testCount++;
      if (rd !== 32'hAAAA_0001) begin
         failCount++;
         $display("[TB] FAIL wrap_word1023: got %h, required aaaa0001", rd);
      end
      readWord(32'h0, rd);
      testCount++;
      if (rd !== expWord0) begin
         failCount++;
         $display("[TB] FAIL wrap_word0: got %h, required %h", rd, expWord0);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [1:0]  resp;
      logic [31:0] rd;
      bHsCount = 0;
      sendAw(32'h100, 8'd3);
      sendBeat(32'h0000_0111, 4'hF, 1'b0);
      sendBeat(32'h0000_0222, 4'hF, 1'b0);
      rst = 1'b1;
      tick();
      testCount++;
      if ({awready, wready, bvalid} !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL midrst_outputs: got aw/w/b=%b, required 000", {awready, wready, bvalid});
      end
      rst = 1'b0;
      tick();
      testCount++;
      if ({awready, wready, bvalid} !== 3'b100 || bHsCount !== 0) begin
         failCount++;
         $display("[TB] FAIL midrst_release: got aw/w/b=%b bHs=%0d, required 100 bHs=0", {awready, wready, bvalid}, bHsCount);
      end
      readWord(32'h100, rd);
      testCount++;
      if (rd !== 32'h0000_0111) begin
         failCount++;
         $display("[TB] FAIL midrst_data0: got %h, required 00000111", rd);
      end
      readWord(32'h104, rd);
      testCount++;
      if (rd !== 32'h0000_0222) begin
         failCount++;
         $display("[TB] FAIL midrst_data1: got %h, required 00000222", rd);
      end
      sendAw(32'h200, 8'd0);
      sendBeat(32'h1234_5678, 4'hF, 1'b1);
      getResp(resp);
      testCount++;
      if (resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL midrst_new_resp: got %b, required 00", resp);
      end
      readWord(32'h200, rd);
      testCount++;
      if (rd !== 32'h1234_5678) begin
         failCount++;
         $display("[TB] FAIL midrst_new_data: got %h, required 12345678", rd);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      rst      = 1'b1;
      awvalid  = 1'b0;
      awaddr   = '0;
      awlen    = '0;
      wvalid   = 1'b0;
      wdata    = '0;
      wstrb    = '0;
      wlast    = 1'b0;
      bready   = 1'b0;
      dbg_addr = '0;
      test_reset();
      test_single_beat();
      test_strobes();
      test_burst_gaps();
      test_wlast_error();
      test_wrap();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/dmem_axi_wr.md
Name: dmem_axi_wr

Overview:
- AXI write-channel responder backed by a word-addressed data memory.
- Sits opposite the write-side initiators (data cache write-back, store path), and is the write counterpart of the instruction-memory read responder on the AXI bus.
- Accepts one AW burst descriptor, then the matching W beats with byte strobes, then returns one B response.
- Provides a registered debug read port so benches can check memory contents.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data beat width; fixed at 32 (4 strobe bits).
- DEPTH_WORDS, 1024, memory depth in 32-bit words; power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- awaddr  in  ADDR_WIDTH  burst start byte address; bits [1:0] ignored.
- awlen  in  8  beats minus one (INCR burst only).
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- wdata  in  DATA_WIDTH  beat data.
- wstrb  in  4  byte enables; wstrb[i] covers wdata[8i+7:8i].
- wlast  in  1  last beat marker from the initiator.
- bvalid  out  1  write-response valid.
- bready  in  1  write-response ready.
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- dbg_addr  in  ADDR_WIDTH  debug read byte address.
- dbg_rdata  out  DATA_WIDTH  debug read data, one cycle after dbg_addr.

Behaviour:
- Reset:
  - rst is sampled on the clk edge. While rst is high: state goes to IDLE, awready=0, wready=0, bvalid=0, bresp=2'b00, dbg_rdata=0.
  - Memory array is not cleared.
  - rst mid-burst abandons the burst. Beats already written remain. No B response is issued.
- FSM states: IDLE, DATA, RESP. awready=(state==IDLE), wready=(state==DATA), bvalid=(state==RESP). All three are forced to 0 while rst is high.
- IDLE:
  - awready=1 from the first cycle after rst deasserts.
  - On awvalid&&awready (cycle T): latch word address awaddr[ADDR_WIDTH-1:2], latch beat count awlen+1, clear the error flag, go to DATA.
- DATA:
  - wready=1 from T+1. Each wvalid&&wready cycle writes one beat.
  - For each byte i with wstrb[i]=1, write the byte into the current word. Bytes with wstrb[i]=0 are unchanged.
  - After each beat the word address increments by 1.
  - Exactly awlen+1 beats are accepted. The burst ends on the count, never on wlast.
  - If wlast is 1 on a non-final beat, or 0 on the final beat, set the error flag. The data is still written.
  - After the final beat handshake, go to RESP on the next cycle.
  - wvalid low stalls the burst with no timeout.
- RESP:
  - bvalid=1, bresp=SLVERR if the error flag is set, else OKAY.
  - bvalid and bresp hold stable until bready. On bvalid&&bready, return to IDLE.
  - The next AW can be accepted the cycle after the B handshake.
- Latency:
  - Minimum transaction time is 1 (AW) + awlen+1 (W) + 1 (B) cycles with all valids/readys high.
  - Single-beat burst: AW at T, W at T+1, bvalid at T+2.
- Address arithmetic:
  - Word index = byte address[log2(DEPTH_WORDS)+1:2].
  - Incrementing past DEPTH_WORDS-1 wraps to 0, unless the optional feature is enabled.
- Debug port:
  - dbg_rdata <= mem[dbg_addr word index] every cycle.
  - Read-during-write to the same word returns the old contents.
- Only one outstanding transaction. W beats presented in IDLE or RESP are not accepted (wready=0).

Optional Feature:
- Macro DMEM_OOR_CHECK_EN.
- Defined:
  - Any beat whose full word address (awaddr[ADDR_WIDTH-1:2] + beat offset) is >= DEPTH_WORDS is not written and sets the error flag, giving bresp=SLVERR.
  - In-range beats of the same burst are still written.
  - No wrap.
- Undefined:
  - Upper address bits are ignored. Word index wraps modulo DEPTH_WORDS.
  - Out-of-range accesses alone never cause SLVERR.

Test Plan:
- Single beat: awaddr=0x0000_0010, awlen=0, wdata=0xDEAD_BEEF, wstrb=4'hF, wlast=1 -> bvalid at T+2, bresp=00; dbg_addr=0x10 reads 0xDEAD_BEEF.
- Byte strobes: preload 0x1122_3344 at 0x20, then write wdata=0xAABB_CCDD with wstrb=4'b0101 -> dbg reads 0x11BB_33DD, bresp=00.
- 4-beat burst with wvalid gaps: awaddr=0x40, awlen=3, data 1,2,3,4, wvalid low 2 cycles between beats 2 and 3 -> words 0x40..0x4C hold 1..4; exactly 4 W handshakes; one B.
- wlast error: awlen=1 with wlast=1 on beat 0 -> both beats written, bresp=2'b10; bready held low 3 cycles -> bvalid and bresp stable; awready=0 until the cycle after the B handshake.
- Wrap/OOR: DEPTH_WORDS=1024, awaddr=0x0FFC, awlen=1, data A,B -> without the macro, word 1023=A, word 0=B, bresp=00; with DMEM_OOR_CHECK_EN, word 1023=A, word 0 unchanged, bresp=10.
- Reset mid-burst: awlen=3, rst high after 2 beats -> next cycle awready/wready/bvalid=0; the 2 written beats persist; after release, a new single-beat transaction completes with OKAY.
